// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU share arbiter.
// ALU control encodings match the shared ALU's control_signal field.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    // Wide enough for ALU_LATENCY-1 over the legal latency range 1..15.
    localparam int LAT_CNT_W = 4;

    localparam logic [6:0] ALU_ADD  = 7'b1000000;
    localparam logic [6:0] ALU_AND  = 7'b0000001;
    localparam logic [6:0] ALU_XOR  = 7'b0000010;
    localparam logic [6:0] ALU_COMP = 7'b1001000;
    localparam logic [6:0] ALU_SLL  = 7'b0010011;
    localparam logic [6:0] ALU_SRL  = 7'b0000011;
    localparam logic [6:0] ALU_SRA  = 7'b0100011;

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way grant picker for the ALU share arbiter.
// ALU_ARB_FIXED_PRIO_EN: port 0 always wins on contention; otherwise round-robin on last_grant.
module alu_rr_pick (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic gnt0,
    output logic gnt1
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign gnt0 = valid0;
    assign gnt1 = valid1 & ~valid0;
`else
    // On contention the port that did not win last time goes first.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (valid0 && valid1) begin
            gnt0 = last_grant;
            gnt1 = ~last_grant;
        end else begin
            gnt0 = valid0;
            gnt1 = valid1;
        end
    end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between two requesters: arbitrate, hold operands, wait latency, return result.
// Define ALU_ARB_FIXED_PRIO_EN for fixed port-0 priority (no last_grant register).
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int CTRL_W      = 7,
    parameter int ALU_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,

    output logic              resp0_valid,
    output logic              resp1_valid,
    input  logic              resp_ready,
    output logic [WIDTH-1:0]  resp_result,
    output logic              resp_carry,
    output logic              resp_zero,

    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_control_signal,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_carry_out,
    input  logic              alu_zero
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(ALU_LATENCY - 1);

    arb_state_e           state_q, state_d;
    logic                 owner_q, owner_d;
    logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 carry_q, carry_d;
    logic                 zero_q, zero_d;
    logic                 resp0_valid_q, resp0_valid_d;
    logic                 resp1_valid_q, resp1_valid_d;

    logic gnt0, gnt1;
    logic last_grant;
    logic in_idle;
    logic accept;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic last_grant_q, last_grant_d;
    assign last_grant = last_grant_q;
`else
    assign last_grant = 1'b1;
`endif

    alu_rr_pick u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    assign in_idle = (state_q == IDLE);
    assign accept  = in_idle & (req0_valid | req1_valid);

    // Ready is masked by rst so every output reads 0 while reset is held.
    assign req0_ready = in_idle & gnt0 & ~rst;
    assign req1_ready = in_idle & gnt1 & ~rst;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        lat_cnt_d     = lat_cnt_q;
        a_d           = a_q;
        b_d           = b_q;
        ctrl_d        = ctrl_q;
        result_d      = result_q;
        carry_d       = carry_q;
        zero_d        = zero_q;
        resp0_valid_d = resp0_valid_q;
        resp1_valid_d = resp1_valid_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant_d  = last_grant_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d   = gnt1;
                    a_d       = gnt1 ? req1_a    : req0_a;
                    b_d       = gnt1 ? req1_b    : req0_b;
                    ctrl_d    = gnt1 ? req1_ctrl : req0_ctrl;
                    lat_cnt_d = LAT_INIT;
                    state_d   = BUSY;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_grant_d = gnt1;
`endif
                end
            end
            BUSY: begin
                if (lat_cnt_q == '0) begin
                    result_d      = alu_result;
                    carry_d       = alu_carry_out;
                    zero_d        = alu_zero;
                    resp0_valid_d = ~owner_q;
                    resp1_valid_d = owner_q;
                    state_d       = DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
                end
            end
            DONE: begin
                // Response and ALU operands stay frozen until the consumer takes it.
                if (resp_ready) begin
                    resp0_valid_d = 1'b0;
                    resp1_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            lat_cnt_q     <= '0;
            a_q           <= '0;
            b_q           <= '0;
            ctrl_q        <= '0;
            result_q      <= '0;
            carry_q       <= 1'b0;
            zero_q        <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q  <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            lat_cnt_q     <= lat_cnt_d;
            a_q           <= a_d;
            b_q           <= b_d;
            ctrl_q        <= ctrl_d;
            result_q      <= result_d;
            carry_q       <= carry_d;
            zero_q        <= zero_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q  <= last_grant_d;
`endif
        end
    end

    assign alu_a              = a_q;
    assign alu_b              = b_q;
    assign alu_control_signal = ctrl_q;
    assign resp_result        = result_q;
    assign resp_carry         = carry_q;
    assign resp_zero          = zero_q;
    assign resp0_valid        = resp0_valid_q;
    assign resp1_valid        = resp1_valid_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: stand-in single-cycle ALU, directed + random transactions vs a reference model.
module tb_alu_share_arbiter;
    import alu_arb_pkg::*;

    localparam int WIDTH       = 32;
    localparam int CTRL_W      = 7;
    localparam int ALU_LATENCY = 1;

    typedef struct packed {
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
        logic [CTRL_W-1:0] ctrl;
    } op_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
    logic              resp0_valid, resp1_valid, resp_ready;
    logic [WIDTH-1:0]  resp_result;
    logic              resp_carry, resp_zero;
    logic [WIDTH-1:0]  alu_a, alu_b, alu_result;
    logic [CTRL_W-1:0] alu_control_signal;
    logic              alu_carry_out, alu_zero;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int pref   = 0;   // port that wins when both request together

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .ALU_LATENCY(ALU_LATENCY)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_carry(resp_carry), .resp_zero(resp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control_signal(alu_control_signal),
        .alu_result(alu_result), .alu_carry_out(alu_carry_out), .alu_zero(alu_zero)
    );

    // Behaviour of the shared ALU: {carry, result}.
    function automatic logic [WIDTH:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [CTRL_W-1:0] c);
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] t;
        r = '0;
        t = '0;
        case (c)
            ALU_ADD:  r = {1'b0, a} + {1'b0, b};
            ALU_AND:  r = {1'b0, a & b};
            ALU_XOR:  r = {1'b0, a ^ b};
            ALU_COMP: r[0] = ($signed(a) < $signed(b));
            ALU_SLL:  r = {1'b0, a << b[4:0]};
            ALU_SRL:  r = {1'b0, a >> b[4:0]};
            ALU_SRA:  begin t = $signed(a) >>> b[4:0]; r = {1'b0, t}; end
            default:  r = '0;
        endcase
        return r;
    endfunction

    assign {alu_carry_out, alu_result} = alu_fn(alu_a, alu_b, alu_control_signal);
    assign alu_zero = (alu_result == '0);

    function automatic op_t mk(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [CTRL_W-1:0] c);
        op_t o;
        o.a = a; o.b = b; o.ctrl = c;
        return o;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_flags"}, {58'd0, req0_ready, req1_ready, resp0_valid, resp1_valid, resp_carry, resp_zero}, 64'd0);
        check({tag, "_result"}, {32'd0, resp_result}, 64'd0);
        check({tag, "_alu_ab"}, {alu_a, alu_b}, 64'd0);
        check({tag, "_alu_ctrl"}, {57'd0, alu_control_signal}, 64'd0);
    endtask

    task automatic model_accept(input int win);
`ifdef ALU_ARB_FIXED_PRIO_EN
        pref = 0;
`else
        pref = 1 - win;
`endif
    endtask

    // Called at posedge+1 with the arbiter idle; returns at posedge+1 of the cycle after the response is consumed.
    task automatic transact(input bit v0, input bit v1, input op_t op0, input op_t op1, input int hold, output int win);
        op_t              w_op;
        logic [WIDTH:0]   exp_cr;
        logic [1:0]       exp_v;
        req0_valid = v0; req0_a = op0.a; req0_b = op0.b; req0_ctrl = op0.ctrl;
        req1_valid = v1; req1_a = op1.a; req1_b = op1.b; req1_ctrl = op1.ctrl;
        win    = (v0 && v1) ? pref : (v0 ? 0 : 1);
        w_op   = (win == 0) ? op0 : op1;
        exp_cr = alu_fn(w_op.a, w_op.b, w_op.ctrl);
        exp_v  = (win == 0) ? 2'b10 : 2'b01;

        @(negedge clk);
        check("idle_resp_valid", {62'd0, resp0_valid, resp1_valid}, 64'd0);
        check("grant_ready0", {63'd0, req0_ready}, {63'd0, win == 0});
        check("grant_ready1", {63'd0, req1_ready}, {63'd0, win == 1});
        @(posedge clk);
        model_accept(win);
        #1;
        if (win == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        resp_ready = 1'($urandom_range(0, 1));

        @(negedge clk);
        check("busy_flags", {60'd0, req0_ready, req1_ready, resp0_valid, resp1_valid}, 64'd0);
        check("busy_alu_ab", {alu_a, alu_b}, {w_op.a, w_op.b});
        check("busy_alu_ctrl", {57'd0, alu_control_signal}, {57'd0, w_op.ctrl});
        @(posedge clk);
        #1 resp_ready = 1'b0;

        for (int i = 0; i <= hold; i++) begin
            if (i == hold) resp_ready = 1'b1;
            @(negedge clk);
            check("done_resp_valid", {62'd0, resp0_valid, resp1_valid}, {62'd0, exp_v});
            check("done_result", {32'd0, resp_result}, {32'd0, exp_cr[WIDTH-1:0]});
            check("done_carry_zero", {62'd0, resp_carry, resp_zero},
                  {62'd0, exp_cr[WIDTH], exp_cr[WIDTH-1:0] == '0});
            check("done_ready_low", {62'd0, req0_ready, req1_ready}, 64'd0);
            check("done_alu_ab", {alu_a, alu_b}, {w_op.a, w_op.b});
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b0;
        $display("txn port=%0d ctrl=%b a=%0h b=%0h result=%0h carry=%0b zero=%0b",
                 win, w_op.ctrl, w_op.a, w_op.b, exp_cr[WIDTH-1:0], exp_cr[WIDTH], exp_cr[WIDTH-1:0] == '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        pref = 0;
    endtask

    initial begin
        logic [CTRL_W-1:0] ops [7];
        op_t o0, o1;
        int  w;
        int  exp_w;
        bit  rv0, rv1;
        ops[0] = ALU_ADD; ops[1] = ALU_AND; ops[2] = ALU_XOR; ops[3] = ALU_COMP;
        ops[4] = ALU_SLL; ops[5] = ALU_SRL; ops[6] = ALU_SRA;
        req0_a = '0; req0_b = '0; req0_ctrl = '0;
        req1_a = '0; req1_b = '0; req1_ctrl = '0;

        // Reset state
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        pref = 0;

        // Lone ADD on port 0
        transact(1'b1, 1'b0, mk(32'd10, 32'd101, ALU_ADD), mk('0, '0, '0), 1, w);
        check("add_alone_result", {32'd0, resp_result}, 64'd111);

        // Both request after reset: port 0 first, then port 1
        do_reset();
        o0 = mk(32'd100123, 32'd101230, ALU_AND);
        o1 = mk(32'd100123, 32'd101230, ALU_XOR);
        transact(1'b1, 1'b1, o0, o1, 0, w);
        check("contend_first", w, 0);
        transact(1'b0, 1'b1, o0, o1, 0, w);

        // Both held valid: alternating grants, responses held while not consumed
        for (int k = 0; k < 4; k++) begin
            o0 = mk($urandom, $urandom, ops[$urandom_range(0, 6)]);
            o1 = mk($urandom, $urandom, ops[$urandom_range(0, 6)]);
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_w = 0;
`else
            exp_w = k % 2;
`endif
            transact(1'b1, 1'b1, o0, o1, 2, w);
            check("alternate_grant", w, exp_w);
        end

        // Port 1 ADD to zero
        transact(1'b0, 1'b1, mk('0, '0, '0), mk(32'd10000, -32'sd10000, ALU_ADD), 0, w);

        // Reset pulsed while busy
        req0_valid = 1'b1; req0_a = -32'sd1324; req0_b = 32'd9; req0_ctrl = ALU_SRA;
        @(negedge clk);
        check("rst_pre_ready0", {63'd0, req0_ready}, 64'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd6; req1_ctrl = ALU_ADD;
        rst = 1'b1;
        #1;
        check_outputs_zero("rst_busy_now");
        @(negedge clk);
        check_outputs_zero("rst_busy_held");
        @(posedge clk);
        #1 rst = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        pref = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_no_resp", {62'd0, resp0_valid, resp1_valid}, 64'd0);
            check("post_rst_alu_ctrl", {57'd0, alu_control_signal}, 64'd0);
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b0;
        transact(1'b1, 1'b1, mk(-32'sd1324, 32'd9, ALU_SRA), mk(32'd5, 32'd6, ALU_ADD), 0, w);
        check("post_rst_first_grant", w, 0);

        // Random traffic
        for (int k = 0; k < 24; k++) begin
            rv0 = 1'($urandom_range(0, 1));
            rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
            o0 = mk($urandom, $urandom, ops[$urandom_range(0, 6)]);
            o1 = mk($urandom, $urandom, ops[$urandom_range(0, 6)]);
            transact(rv0, rv1, o0, o1, $urandom_range(0, 2), w);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
